// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory stage of the five-stage pipeline. It decodes the load/store controls
//   from the EXE/MEM register and accesses a little-endian, byte-addressable
//   data memory of 2^ADDR_W 32-bit words. It also produces the MEM/WB pipeline
//   register.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high; clears MEM/WB and drops stores
//   stall_HZD           holds MEM/WB and blocks stores
//   MemRead_EXE_MEM     load type  (1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, else none)
//   MemWrite_EXE_MEM    store type (1 SB, 2 SH, 3 SW, else none)
//   MemtoReg_EXE_MEM    write-back select, passed through
//   RegWrite_EXE_MEM    register write enable, passed through unless misaligned
//   rd_EXE_MEM          destination register, passed through
//   pc_EXE_MEM          instruction PC, passed through
//   ALU_Result_EXE_MEM  effective byte address / ALU result
//   write_data_EXE_MEM  store data (low byte/halfword used for SB/SH)
//   *_MEM_WB            registered outputs; mem_data_MEM_WB holds extended
//                       load data, misalign_MEM_WB flags a suppressed access
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_HZD,
  input  logic [3:0]  MemRead_EXE_MEM,
  input  logic [3:0]  MemWrite_EXE_MEM,
  input  logic [1:0]  MemtoReg_EXE_MEM,
  input  logic        RegWrite_EXE_MEM,
  input  logic [4:0]  rd_EXE_MEM,
  input  logic [14:0] pc_EXE_MEM,
  input  logic [31:0] ALU_Result_EXE_MEM,
  input  logic [31:0] write_data_EXE_MEM,
  output logic [1:0]  MemtoReg_MEM_WB,
  output logic        RegWrite_MEM_WB,
  output logic [4:0]  rd_MEM_WB,
  output logic [14:0] pc_MEM_WB,
  output logic [31:0] ALU_Result_MEM_WB,
  output logic [31:0] mem_data_MEM_WB,
  output logic        misalign_MEM_WB
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int DEPTH = 1 << ADDR_W;

  // Byte-lane storage; lane 0 is bits 7:0 of each word.
  logic [31:0] mem [DEPTH];

  // Address split. Upper ALU bits are dropped, so addresses wrap.
  logic [ADDR_W+1:0] byte_addr;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;

  assign byte_addr = ALU_Result_EXE_MEM[ADDR_W+1:0];
  assign word_idx  = byte_addr[ADDR_W+1:2];
  assign lane      = byte_addr[1:0];

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic  ld_en;
  logic  ld_signed;
  size_e ld_size;
  logic  st_en;
  size_e st_size;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ld_en     = 1'b0;
    ld_signed = 1'b0;
    ld_size   = SZ_BYTE;
    case (MemRead_EXE_MEM)
      4'd1: begin ld_en = 1'b1; ld_signed = 1'b1; ld_size = SZ_BYTE; end
      4'd2: begin ld_en = 1'b1; ld_signed = 1'b1; ld_size = SZ_HALF; end
      4'd3: begin ld_en = 1'b1; ld_size = SZ_WORD; end
      4'd4: begin ld_en = 1'b1; ld_size = SZ_BYTE; end
      4'd5: begin ld_en = 1'b1; ld_size = SZ_HALF; end
      default: ;
    endcase
  end

  always_comb begin
    st_en   = 1'b0;
    st_size = SZ_BYTE;
    case (MemWrite_EXE_MEM)
      4'd1: begin st_en = 1'b1; st_size = SZ_BYTE; end
      4'd2: begin st_en = 1'b1; st_size = SZ_HALF; end
      4'd3: begin st_en = 1'b1; st_size = SZ_WORD; end
      default: ;
    endcase
  end

  function automatic logic is_aligned(input size_e sz, input logic [1:0] ln);
    logic ok;
    ok = 1'b1;
    case (sz)
      SZ_HALF: ok = ~ln[0];
      SZ_WORD: ok = (ln == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  logic ld_aligned;
  logic st_aligned;
  logic access_misalign;
  logic st_fire;

  assign ld_aligned = is_aligned(ld_size, lane);
  assign st_aligned = is_aligned(st_size, lane);

  // A store takes precedence over a simultaneous load, so its alignment is the
  // one that decides whether the access is suppressed.
  assign access_misalign = st_en ? ~st_aligned : (ld_en & ~ld_aligned);
  assign st_fire         = st_en & st_aligned & ~stall_HZD & ~reset;

  // ---------------------------------------------------------------------------
  // Store path: lane enables and lane-replicated data
  // ---------------------------------------------------------------------------
  logic [3:0]  byte_en;
  logic [31:0] st_data;

  always_comb begin
    byte_en = 4'b0000;
    st_data = write_data_EXE_MEM;
    case (st_size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        st_data = {4{write_data_EXE_MEM[7:0]}};
      end
      SZ_HALF: begin
        byte_en = 4'b0011 << {lane[1], 1'b0};
        st_data = {2{write_data_EXE_MEM[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        st_data = write_data_EXE_MEM;
      end
    endcase
  end

  // NOTE: the memory array has no reset branch; contents survive reset and are
  // undefined until written, which keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    if (st_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: select lane(s) and extend
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'h0;
    // Misaligned loads and the illegal load+store combination return zero.
    if (ld_en && !st_en && ld_aligned) begin
      case (ld_size)
        SZ_BYTE: load_data = ld_signed ? {{24{rd_byte[7]}}, rd_byte}
                                       : {24'h0, rd_byte};
        SZ_HALF: load_data = ld_signed ? {{16{rd_half[15]}}, rd_half}
                                       : {16'h0, rd_half};
        default: load_data = rd_word;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB pipeline register (reset beats stall)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      MemtoReg_MEM_WB   <= 2'b00;
      RegWrite_MEM_WB   <= 1'b0;
      rd_MEM_WB         <= 5'd0;
      pc_MEM_WB         <= 15'd0;
      ALU_Result_MEM_WB <= 32'h0;
      mem_data_MEM_WB   <= 32'h0;
      misalign_MEM_WB   <= 1'b0;
    end else if (!stall_HZD) begin
      MemtoReg_MEM_WB   <= MemtoReg_EXE_MEM;
      RegWrite_MEM_WB   <= RegWrite_EXE_MEM & ~access_misalign;
      rd_MEM_WB         <= rd_EXE_MEM;
      pc_MEM_WB         <= pc_EXE_MEM;
      ALU_Result_MEM_WB <= ALU_Result_EXE_MEM;
      mem_data_MEM_WB   <= load_data;
      misalign_MEM_WB   <= access_misalign;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline: the consumer of the EXE/MEM pipeline register driven by `EXE_stage`. It decodes the 4-bit load/store controls and accesses an internal byte-addressable data memory with 1-cycle synchronous latency. It produces the MEM/WB pipeline register, including `ALU_Result_MEM_WB`, which feeds back to the EXE forwarding mux.

## Interface
- `ADDR_W`, 10: word-address width; memory holds 2^ADDR_W 32-bit words.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall_HZD` in 1: freezes the MEM/WB register and blocks stores.
- `MemRead_EXE_MEM` in 4: load type: 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU; other codes are treated as none.
- `MemWrite_EXE_MEM` in 4: store type: 0000 none, 0001 SB, 0010 SH, 0011 SW; other codes are treated as none.
- `MemtoReg_EXE_MEM` in 2: write-back select, passed through (00 ALU, 01 mem, 10 pc link).
- `RegWrite_EXE_MEM` in 1: register write enable.
- `rd_EXE_MEM` in 5: destination register.
- `pc_EXE_MEM` in 15: instruction PC.
- `ALU_Result_EXE_MEM` in 32: effective byte address, or ALU result.
- `write_data_EXE_MEM` in 32: store data; the low byte or halfword is used for SB/SH.
- `MemtoReg_MEM_WB` out 2, `RegWrite_MEM_WB` out 1, `rd_MEM_WB` out 5, `pc_MEM_WB` out 15: registered pass-through.
- `ALU_Result_MEM_WB` out 32: registered ALU result.
- `mem_data_MEM_WB` out 32: registered, extended load data.
- `misalign_MEM_WB` out 1: the registered access was misaligned and was suppressed.

## Operation
- Byte address A = `ALU_Result_EXE_MEM[ADDR_W+1:0]`.
  - Word index = A[ADDR_W+1:2]; lane = A[1:0].
  - Upper address bits are ignored, so addresses wrap modulo memory size.
- Memory is little-endian: lane 0 = bits 7:0.
- Alignment rules:
  - Byte accesses are always aligned.
  - Halfword accesses require A[0]=0.
  - Word accesses require A[1:0]=00.
  - A misaligned access performs no read or write and sets `misalign_MEM_WB`=1.
  - On a misaligned access, `RegWrite_MEM_WB` is forced to 0; the other fields still register normally.
- Stores write on the rising edge when all of these hold: the store is valid and aligned, `stall_HZD`=0, `reset`=0.
  - SB writes only the addressed byte lane.
  - SH writes lanes {A[1],0} and {A[1],1}.
  - SW writes all four lanes.
- Loads read the addressed word on the edge and register it into `mem_data_MEM_WB`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - With no load, `mem_data_MEM_WB` = 0.
- If both MemRead and MemWrite are nonzero, the store is performed and `mem_data_MEM_WB` = 0. This is an illegal-combination guard.
- Stall (`stall_HZD`=1): all MEM_WB outputs hold their previous values and memory is unchanged.
- Memory contents are not affected by reset. Contents are undefined until written.

## Timing
- Reset (`reset`=1 at an edge): every MEM_WB output becomes 0, including `misalign_MEM_WB`. Any store presented in the same cycle is dropped.
- Reset takes priority over stall.
- Latency: EXE_MEM inputs at edge n appear on MEM_WB outputs after edge n; the store is committed at edge n.
- Store-to-load ordering:
  - A store at edge n followed by a load of the same address at edge n+1 returns the new data.
  - No bypass is needed; the memory write completes before the next read.
- Outputs are purely registered, with no combinational path from inputs to outputs.
- Release from stall: the held values stay valid until the first edge with `stall_HZD`=0, which captures the current inputs.

## Test plan
- SW 0xDEADBEEF to A=0x10, then LW A=0x10 with RegWrite=1, rd=5. Required next cycle:
  - `mem_data_MEM_WB`=0xDEADBEEF, `RegWrite_MEM_WB`=1, `rd_MEM_WB`=5, `misalign_MEM_WB`=0.
- Build a word from byte stores, then load it back:
  - SB 0x11 at 0x20, 0x22 at 0x21, 0x33 at 0x22, 0x44 at 0x23; LW 0x20 returns 0x44332211.
  - SH 0xAAAA at 0x22; LW 0x20 returns 0xAAAA2211.
- Sign and zero extension: SW 0x0000807F to 0x30, then:
  - LB 0x31 → 0xFFFFFF80; LBU 0x31 → 0x00000080.
  - LH 0x30 → 0xFFFF807F; LHU 0x30 → 0x0000807F.
- Misaligned accesses:
  - LW at 0x42 with RegWrite=1 → `misalign_MEM_WB`=1, `RegWrite_MEM_WB`=0, `mem_data_MEM_WB`=0.
  - SH at 0x41 leaves word 0x40 unchanged; confirm with a following LW.
- Stall: with `stall_HZD`=1 for 3 cycles while presenting SW 0x12345678 to 0x50 and changing rd:
  - Outputs hold their prior values and memory is unchanged (LW 0x50 afterwards returns the old data).
  - After release, the next edge captures the current inputs.
- Reset mid-operation: assert `reset` for 1 cycle during an SW 0xCAFEF00D to 0x60.
  - All outputs become 0 on the next edge.
  - A subsequent LW 0x60 returns the pre-reset contents (the store was dropped).
  - `pc_MEM_WB` and `ALU_Result_MEM_WB` resume on the first non-reset edge.
